// File: rtl/delay_mem_ctrl.sv
// Delay-line RAM responder: serializes read-before-write requests and tracks write fill.
// Optional DELAY_MEM_CLEAR_EN zeroes the whole RAM after reset release.
module delay_mem_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_wr_addr,
   input  logic [ADDR_W-1:0] req_rd_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              primed
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RSP
`ifdef DELAY_MEM_CLEAR_EN
      , CLEAR
`endif
   } state_e;

`ifdef DELAY_MEM_CLEAR_EN
   localparam state_e RST_STATE = CLEAR;
`else
   localparam state_e RST_STATE = IDLE;
`endif

   state_e              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]    fill_q, fill_d;
   logic                primed_q, primed_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef DELAY_MEM_CLEAR_EN
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
`endif

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word_q;
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_waddr_c;
   logic [DATA_W-1:0]   mem_wdata_c;
   logic                rd_en_c;

   // State and control registers; RAM contents are never reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RST_STATE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         fill_q      <= '0;
         primed_q    <= 1'b0;
         we_q        <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         wdata_q     <= '0;
`ifdef DELAY_MEM_CLEAR_EN
         clr_addr_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         fill_q      <= fill_d;
         primed_q    <= primed_d;
         we_q        <= we_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         wdata_q     <= wdata_d;
`ifdef DELAY_MEM_CLEAR_EN
         clr_addr_q  <= clr_addr_d;
`endif
      end
   end

   // Next-state, RAM control and registered output decode
   always_comb begin
      state_d     = state_q;
      rsp_data_d  = rsp_data_q;
      fill_d      = fill_q;
      we_d        = we_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      wdata_d     = wdata_q;
`ifdef DELAY_MEM_CLEAR_EN
      clr_addr_d  = clr_addr_q;
`endif
      mem_we_c    = 1'b0;
      mem_waddr_c = wr_addr_q;
      mem_wdata_c = wdata_q;
      rd_en_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d      = req_we;
               wr_addr_d = req_wr_addr;
               rd_addr_d = req_rd_addr;
               wdata_d   = req_wdata;
               state_d   = RD;
            end
         end
         RD: begin
            rd_en_c = 1'b1;
            state_d = WR;
         end
         WR: begin
            // Read word was captured a cycle earlier, so same-address requests return old data
            rsp_data_d = rd_word_q;
            if (we_q) begin
               mem_we_c = 1'b1;
               if (fill_q != FILL_FULL) begin
                  fill_d = fill_q + CNT_W'(1);
               end
            end
            state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
`ifdef DELAY_MEM_CLEAR_EN
         CLEAR: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_addr_q;
            mem_wdata_c = '0;
            clr_addr_d  = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
      primed_d    = (fill_d == FILL_FULL);
   end

   // Single-port-style RAM with registered read
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_waddr_c] <= mem_wdata_c;
      end
      if (rd_en_c) begin
         rd_word_q <= mem[rd_addr_q];
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign primed    = primed_q;

endmodule

// File: tb/tb_delay_mem_ctrl.sv
// Directed self-checking bench for delay_mem_ctrl at ADDR_W=4.
module tb_delay_mem_ctrl;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_wr_addr;
   logic [ADDR_W-1:0] req_rd_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              primed;

   int n_checks = 0;
   int n_errors = 0;

   delay_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_wr_addr (req_wr_addr),
      .req_rd_addr (req_rd_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .primed      (primed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge; optionally stall the response for hold cycles.
   task automatic do_req(input string tag, input logic we, input logic [3:0] wa,
                         input logic [3:0] ra, input logic [15:0] wd, input int hold,
                         input logic chk, input logic [15:0] exp);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
      rsp_ready   = (hold == 0);
      req_valid   = 1'b1;
      req_we      = we;
      req_wr_addr = wa;
      req_rd_addr = ra;
      req_wdata   = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid   = 1'b0;
      req_we      = ~we;
      req_wdata   = 16'hDEAD;
      check_eq({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      n = 1;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_latency"}, n, 3);
      if (chk) check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         req_valid   = 1'b1;
         req_we      = 1'b1;
         req_wr_addr = ra;
         req_rd_addr = ra;
         req_wdata   = 16'hFFFF;
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check_eq({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
         check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [3:0] fill_addrs [12];
      logic [15:0] exp2;
      fill_addrs = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};

      reset       = 1'b1;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_wr_addr = '0;
      req_rd_addr = '0;
      req_wdata   = '0;
      rsp_ready   = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
      check_eq("rst_primed", 32'(primed), 32'd0);
      reset = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         check_eq("clear_busy", 32'(req_ready), 32'd0);
      end
`endif
      @(negedge clk);
      check_eq("post_rst_ready", 32'(req_ready), 32'd1);

`ifdef DELAY_MEM_CLEAR_EN
      do_req("clr_rd9", 1'b0, 4'd0, 4'd9, 16'h0, 0, 1'b1, 16'h0000);
`endif
      // Basic write then read-back
      do_req("wr3", 1'b1, 4'd3, 4'd5, 16'h1234, 0, 1'b0, 16'h0);
      do_req("rd3", 1'b0, 4'd0, 4'd3, 16'h0, 0, 1'b1, 16'h1234);
      check_eq("primed_early", 32'(primed), 32'd0);

      // Same address returns old content
      do_req("wr7", 1'b1, 4'd7, 4'd3, 16'h00AA, 0, 1'b1, 16'h1234);
      do_req("same7", 1'b1, 4'd7, 4'd7, 16'h0055, 0, 1'b1, 16'h00AA);
      do_req("rd7", 1'b0, 4'd0, 4'd7, 16'h0, 0, 1'b1, 16'h0055);

      // Backpressure with an ignored write request during the stall
      do_req("bp7", 1'b0, 4'd0, 4'd7, 16'h0, 10, 1'b1, 16'h0055);
      do_req("rd7b", 1'b0, 4'd0, 4'd7, 16'h0, 0, 1'b1, 16'h0055);

      // Fill: 3 writes so far, 12 more makes 15
      foreach (fill_addrs[i])
         do_req("fill", 1'b1, fill_addrs[i], 4'd3, 16'h1000 + 16'(fill_addrs[i]), 0, 1'b1, 16'h1234);
      check_eq("primed_15", 32'(primed), 32'd0);
      do_req("rd12", 1'b0, 4'd0, 4'd12, 16'h0, 0, 1'b1, 16'h100C);
      check_eq("primed_15_rd", 32'(primed), 32'd0);
      do_req("wr14", 1'b1, 4'd14, 4'd2, 16'h100E, 0, 1'b1, 16'h1002);
      check_eq("primed_16", 32'(primed), 32'd1);
      do_req("rd14", 1'b0, 4'd0, 4'd14, 16'h0, 0, 1'b1, 16'h100E);
      check_eq("primed_hold", 32'(primed), 32'd1);

      // Reset while in RD drops the pending write
      req_valid   = 1'b1;
      req_we      = 1'b1;
      req_wr_addr = 4'd2;
      req_rd_addr = 4'd2;
      req_wdata   = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
      check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("mid_rst_data", 32'(rsp_data), 32'd0);
      check_eq("mid_rst_primed", 32'(primed), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
      exp2 = 16'h0000;
`else
      exp2 = 16'h1002;
`endif
      @(negedge clk);
      do_req("rd2", 1'b0, 4'd0, 4'd2, 16'h0, 0, 1'b1, exp2);
      check_eq("primed_after_rst", 32'(primed), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/delay_mem_ctrl.md
# delay_mem_ctrl

Memory-side responder for the echo delay line: owns the sample delay RAM and services the combined write-sample / read-delayed-sample request that the echo effect issues once per audio sample. Each request is serialized as read-before-write through a small FSM and answered over a valid/ready response channel. A write-fill counter reports when the whole delay line holds real audio.

## Interface
- `DATA_W`, default 16: signed sample width.
- `ADDR_W`, default 16: address width; depth is 2**ADDR_W words.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  perform the write part of the request.
- `req_wr_addr`  in  ADDR_W  write address.
- `req_rd_addr`  in  ADDR_W  read address.
- `req_wdata`  in  DATA_W  sample to store.
- `rsp_valid`  out  1  `rsp_data` holds the read result.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_W  word read from `req_rd_addr`.
- `primed`  out  1  at least 2**ADDR_W writes performed since reset.

## Operation
- States: IDLE, RD, WR, RSP (plus CLEAR when configured).
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch all request fields, go to RD.
- RD: synchronous RAM read of latched read address issued; go to WR.
- WR: `rsp_data` <= RAM read word; if latched `req_we`, write latched `req_wdata` to latched write address; go to RSP.
- RSP: `rsp_valid`=1, `rsp_data` stable; on `rsp_valid && rsp_ready`, go to IDLE.
- Read-before-write: when write and read addresses are equal, `rsp_data` is the old content, never the new sample.
- Request inputs are ignored outside IDLE; only latched copies are used.
- Addresses are plain ADDR_W-bit values; wrap-around (e.g. 65535 -> 0) is the requester's job, no range checking.
- Fill counter: ADDR_W+1 bits, increments on each performed write, saturates at 2**ADDR_W; `primed` = (counter == 2**ADDR_W). Never decrements.
- Data path is pass-through; no arithmetic on samples.

## Timing
- Reset values: `req_ready`=0 during reset, then per state; `rsp_valid`=0, `rsp_data`=0, `primed`=0, fill counter 0, state IDLE (or CLEAR).
- Accept at edge E0 -> RD; E1 -> WR; E2 -> RSP with `rsp_valid`=1 visible after E2. Latency: 3 cycles from accepting edge to `rsp_valid`.
- With `rsp_ready` held high: response consumed at E3, `req_ready`=1 after E3; throughput one request per 4 cycles.
- Backpressure: `rsp_valid`/`rsp_data` held indefinitely while `rsp_ready`=0; `req_ready` stays 0.
- `req_ready` is a registered-state decode (not combinational from `req_valid`).
- Reset mid-operation: any pending request dropped; write not performed if reset asserts before the WR edge; all outputs return to reset values asynchronously. RAM contents otherwise untouched.

## Configuration
- `DELAY_MEM_CLEAR_EN` defined: after reset release, state CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle, `req_ready`=0 throughout, then IDLE. Clear writes do not increment the fill counter. Reset during CLEAR restarts it from address 0.
- Not defined: no CLEAR state; IDLE with `req_ready`=1 on the first cycle after reset release; unwritten RAM content is undefined.

## Test plan
- ADDR_W=4, no clear: write 0x1234 to addr 3 (read addr 5), then request read addr 3 -> second response `rsp_data`=0x1234, `rsp_valid` exactly 3 cycles after each accept.
- Same-address: store 0x00AA at addr 7; request we=1, wr=rd=7, wdata=0x0055 -> `rsp_data`=0x00AA; next read of 7 -> 0x0055.
- Backpressure: `rsp_ready`=0 for 10 cycles in RSP -> `rsp_valid`=1 and `rsp_data` constant, `req_ready`=0, new `req_valid` ignored; response consumed on `rsp_ready` edge.
- Fill: ADDR_W=4, 15 writes -> `primed`=0; 16th write -> `primed`=1; requests with we=0 never change it.
- Reset asserted in RD with we=1, wdata=0xBEEF at addr 2 -> outputs at reset values immediately; later read of addr 2 does not return 0xBEEF.
- With `DELAY_MEM_CLEAR_EN`, ADDR_W=4: `req_ready`=0 for 16 cycles after reset release, then 1; read of any address -> 0x0000; `primed`=0.
